// File: rtl/lc3_alu_seq.sv
// Multi-cycle LC-3 style ALU with iterative shifts and shift-add multiply,
// valid/ready handshakes on both sides and a registered NZP condition code.
module lc3_alu_seq #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUK,
  input  logic [WIDTH-1:0] SR1,
  input  logic [WIDTH-1:0] SR2,
  input  logic [IMM_W-1:0] IMM,
  input  logic             SR2MUX,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic [2:0]       NZP,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH for MUL.
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_AND = 3'b001, OP_PASS = 3'b010, OP_NOT = 3'b011,
    OP_SHL = 3'b100, OP_SHR = 3'b101, OP_SRA  = 3'b110, OP_MUL = 3'b111
  } alu_op_e;

  state_e           state;
  alu_op_e          op;
  logic [WIDTH-1:0] work;  // shift operand / shifted multiplicand
  logic [WIDTH-1:0] mpl;   // multiplier, consumed LSB first
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_sel, simple_res, shift_step, mul_acc, exec_res;
  logic [SW-1:0]    k;
  alu_op_e          req_op;

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])   return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  always_comb begin
    req_op     = alu_op_e'(ALUK);
    b_sel      = SR2MUX ? {{(WIDTH-IMM_W){IMM[IMM_W-1]}}, IMM} : SR2;
    k          = b_sel[SW-1:0];
    simple_res = SR1;
    case (req_op)
      OP_ADD:  simple_res = SR1 + b_sel;
      OP_AND:  simple_res = SR1 & b_sel;
      OP_NOT:  simple_res = ~SR1;
      default: simple_res = SR1;
    endcase
    shift_step = work;
    case (op)
      OP_SHL:  shift_step = {work[WIDTH-2:0], 1'b0};
      OP_SHR:  shift_step = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  shift_step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shift_step = work;
    endcase
    mul_acc  = acc + (mpl[0] ? work : '0);
    exec_res = (op == OP_MUL) ? mul_acc : shift_step;
  end

  // in_ready is held low while reset is asserted.
  assign in_ready = Reset_n && (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      op        <= OP_ADD;
      work      <= '0;
      mpl       <= '0;
      acc       <= '0;
      cnt       <= '0;
      OUT       <= '0;
      NZP       <= 3'b000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op   <= req_op;
          work <= SR1;
          mpl  <= b_sel;
          acc  <= '0;
          case (req_op)
            OP_SHL, OP_SHR, OP_SRA: begin
              if (k == '0) begin
                OUT       <= SR1;
                NZP       <= nzp_of(SR1);
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                cnt   <= {1'b0, k};
                state <= EXEC;
              end
            end
            OP_MUL: begin
              cnt   <= CW'(WIDTH);
              state <= EXEC;
            end
            default: begin
              OUT       <= simple_res;
              NZP       <= nzp_of(simple_res);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          endcase
        end
        EXEC: begin
          if (op == OP_MUL) begin
            acc  <= mul_acc;
            work <= {work[WIDTH-2:0], 1'b0};
            mpl  <= {1'b0, mpl[WIDTH-1:1]};
          end else begin
            work <= shift_step;
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            OUT       <= exec_res;
            NZP       <= nzp_of(exec_res);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_alu_seq.sv
// Directed bench for lc3_alu_seq: hand-computed vectors, stall, reset mid-MUL
// and back-to-back ADD/AND against a small golden model.
module tb_lc3_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, SR2MUX, out_valid, out_ready, busy;
  logic [2:0]  ALUK, NZP;
  logic [15:0] SR1, SR2, OUT;
  logic [4:0]  IMM;

  int errs = 0;
  int checks = 0;

  lc3_alu_seq #(.WIDTH(16), .IMM_W(5)) dut (
    .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUK(ALUK), .SR1(SR1), .SR2(SR2), .IMM(IMM), .SR2MUX(SR2MUX),
    .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT), .NZP(NZP),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] nzp_ref(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0) return 3'b010;
    return 3'b001;
  endfunction

  // Issue one op, scramble operands after accept, measure latency,
  // optionally stall with out_ready low, then consume the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] imm, input logic mux,
                        input logic [15:0] eout, input logic [2:0] enzp,
                        input int elat, input int stall);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    ALUK = op; SR1 = a; SR2 = b; IMM = imm; SR2MUX = mux;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    SR1 = 16'($urandom); SR2 = 16'($urandom); IMM = 5'($urandom); SR2MUX = ~mux;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".out"}, OUT, eout);
    chk({tag, ".nzp"}, NZP, enzp);
    chk({tag, ".busy"}, busy, 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ALUK = 3'b000; SR1 = 16'h1111; SR2 = 16'h2222; SR2MUX = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".stall_out"}, OUT, eout);
      chk({tag, ".stall_nzp"}, NZP, enzp);
      chk({tag, ".stall_vld"}, out_valid, 1);
      chk({tag, ".stall_rdy"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".consumed"}, out_valid, 0);
    chk({tag, ".idle_rdy"}, in_ready, 1);
    chk({tag, ".hold_out"}, OUT, eout);
  endtask

  initial begin
    logic [15:0] a, b, exp;
    logic        stray;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUK = '0; SR1 = '0; SR2 = '0; IMM = '0; SR2MUX = 1'b0;
    #12;
    chk("rst.out", OUT, 16'h0);
    chk("rst.nzp", NZP, 3'b000);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel.in_ready", in_ready, 1);

    run_op("add_imm",  3'b000, 16'h7FFF, 16'h0000, 5'b11111, 1'b1, 16'h7FFE, 3'b001, 1, 0);
    run_op("add_zero", 3'b000, 16'h8000, 16'h8000, 5'b00000, 1'b0, 16'h0000, 3'b010, 1, 0);
    run_op("and_imm",  3'b001, 16'h00F0, 16'hFFFF, 5'b01100, 1'b1, 16'h0000, 3'b010, 1, 0);
    run_op("pass",     3'b010, 16'h1234, 16'hFFFF, 5'b00000, 1'b0, 16'h1234, 3'b001, 1, 0);
    run_op("not_stall",3'b011, 16'h00FF, 16'h0000, 5'b00000, 1'b0, 16'hFF00, 3'b100, 1, 4);
    run_op("sra4",     3'b110, 16'h8010, 16'h0004, 5'b00000, 1'b0, 16'hF801, 3'b100, 5, 0);
    run_op("shr4",     3'b101, 16'h8010, 16'h0004, 5'b00000, 1'b0, 16'h0801, 3'b001, 5, 0);
    run_op("shl_k0",   3'b100, 16'h8010, 16'h0010, 5'b00000, 1'b0, 16'h8010, 3'b100, 1, 0);
    run_op("shl3",     3'b100, 16'h0011, 16'hFFF3, 5'b00000, 1'b0, 16'h0088, 3'b001, 4, 0);
    run_op("mul_neg",  3'b111, 16'hFFFF, 16'h0003, 5'b00000, 1'b0, 16'hFFFD, 3'b100, 17, 0);
    run_op("mul_ovf",  3'b111, 16'h0100, 16'h0100, 5'b00000, 1'b0, 16'h0000, 3'b010, 17, 0);
    run_op("add_pre",  3'b000, 16'h1000, 16'h0234, 5'b00000, 1'b0, 16'h1234, 3'b001, 1, 0);

    // Reset during the fifth EXEC cycle of a MUL.
    @(negedge clk);
    ALUK = 3'b111; SR1 = 16'hFFFF; SR2 = 16'h0003; SR2MUX = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_mul.busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("mrst.out", OUT, 16'h0);
    chk("mrst.nzp", NZP, 3'b000);
    chk("mrst.out_valid", out_valid, 0);
    chk("mrst.busy", busy, 0);
    chk("mrst.in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("mrel.in_ready", in_ready, 1);
    stray = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      stray = stray | out_valid | busy;
    end
    chk("mrel.no_stray", stray, 0);

    // Back-to-back ADD/AND, in_valid and out_ready tied high.
    out_ready = 1'b1; in_valid = 1'b1; SR2MUX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b.in_ready", in_ready, 1);
      a = 16'($urandom); b = 16'($urandom);
      if (i == 3) b = 16'h0000;
      ALUK = (i % 2 == 0) ? 3'b000 : 3'b001;
      SR1 = a; SR2 = b;
      exp = (i % 2 == 0) ? a + b : a & b;
      @(posedge clk); #1;
      SR1 = ~a; SR2 = ~b; ALUK = 3'b011;
      chk("b2b.out_valid", out_valid, 1);
      chk("b2b.out", OUT, exp);
      chk("b2b.nzp", NZP, nzp_ref(exp));
      @(posedge clk); #1;
      chk("b2b.out_drop", out_valid, 0);
      chk("b2b.hold", OUT, exp);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/lc3_alu_seq.md
# lc3_alu_seq

Multi-cycle, parametrised successor to the LC-3 datapath ALU. It adds shift and multiply operations, a valid/ready handshake on both sides, and an NZP condition-code register. It sits between the register file / SR2MUX path and the bus driver. It accepts one operation at a time, executes iterative ops over several cycles, and holds the result until the consumer takes it.

## Interface
- WIDTH, 16, datapath width (≥4)
- IMM_W, 5, immediate field width, sign-extended to WIDTH
- Clk  in  1  clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request (high only in IDLE)
- ALUK  in  3  opcode: 000 ADD, 001 AND, 010 PASS(SR1), 011 NOT(SR1), 100 SHL, 101 SHR (logical), 110 SRA, 111 MUL
- SR1  in  WIDTH  operand A
- SR2  in  WIDTH  register operand B
- IMM  in  IMM_W  immediate operand
- SR2MUX  in  1  0: B=SR2, 1: B=sign-extended IMM
- out_valid  out  1  OUT/NZP hold a new result
- out_ready  in  1  consumer takes result
- OUT  out  WIDTH  result register
- NZP  out  3  {N,Z,P} of the last delivered result
- busy  out  1  state is EXEC or DONE

## Operation
- States: IDLE, EXEC, DONE.
- On accept (in_valid && in_ready), the block latches ALUK, SR1 and the selected B. Later input changes have no effect on the operation.
- ADD/AND/PASS/NOT:
  - The result is computed from the latched operands.
  - The FSM goes IDLE→DONE at the accept edge.
  - ADD wraps modulo 2^WIDTH; no carry out.
- SHL/SHR/SRA:
  - Shift count k = B[$clog2(WIDTH)-1:0]; the upper bits of B are ignored.
  - k=0: IDLE→DONE, OUT=A.
  - k>0: enter EXEC with a counter set to k. Each EXEC cycle shifts the working register one bit and decrements the counter.
  - When the counter reaches 0, go EXEC→DONE.
  - SHR fills with 0; SRA replicates the MSB.
- MUL:
  - Shift-add over the latched operands, one multiplier bit per EXEC cycle, exactly WIDTH EXEC cycles.
  - OUT = low WIDTH bits of A×B; identical for signed and unsigned.
- DONE:
  - OUT and NZP are loaded on the edge entering DONE.
  - NZP = 100 if OUT[WIDTH-1]; otherwise 010 if OUT==0; otherwise 001.
  - out_valid=1; OUT and NZP are held stable until out_ready.
  - out_valid && out_ready → IDLE at that edge. No new accept in the same cycle, since in_ready=0 in DONE.
- OUT and NZP keep their last value in IDLE and EXEC; they change only on entry to DONE.
- in_valid while busy is ignored (not queued).
- out_ready while out_valid=0 is ignored.
- Reset (async, any state):
  - state=IDLE, OUT=0, NZP=000, out_valid=0, busy=0.
  - Counters and working registers are cleared.
  - in_ready=1 once Reset_n deasserts.
  - An operation in flight is discarded; no result is produced.

## Timing
- Accept at edge e0. out_valid rises after:
  - e0, for simple ops and shift k=0 (latency 1)
  - e0+k, for shifts with k>0 (latency k+1)
  - e0+WIDTH, for MUL (latency WIDTH+1)
- in_ready=0 from e0 until the edge that consumes the result.
- Minimum issue interval is 2 cycles (accept, DONE with out_ready=1).
- out_ready held low stalls indefinitely in DONE with outputs stable.
- All outputs are registered except in_ready and busy, which decode directly from the state register.

## Test plan
- Reset with WIDTH=16:
  - Assert Reset_n=0 mid-MUL (EXEC cycle 5).
  - Required: immediately OUT=0000, NZP=000, out_valid=0, busy=0, in_ready=0 until release.
  - After release: no stray out_valid, in_ready=1.
- ADD with immediate:
  - SR1=0x7FFF, SR2MUX=1, IMM=5'b11111.
  - Required: OUT=0x7FFE, NZP=001, out_valid one cycle after accept.
  - Then SR1=0x8000, ADD B=0x8000 → OUT=0x0000, NZP=010.
- NOT with stall:
  - NOT SR1=0x00FF, out_ready held low 4 cycles.
  - Required: OUT=0xFF00, NZP=100, stable all 4 cycles; in_ready=0 throughout.
  - in_valid pulses during the stall are ignored.
- Shifts:
  - SRA SR1=0x8010, SR2=0x0004 → OUT=0xF801 after 5 cycles.
  - SHR same operands → 0x0801.
  - SHL SR2=0x0010 (k=0) → 0x8010, latency 1.
- MUL:
  - SR1=0xFFFF, SR2=0x0003 → OUT=0xFFFD, NZP=100, latency 17.
  - 0x0100×0x0100 → OUT=0x0000, NZP=010.
- Back-to-back throughput:
  - in_valid and out_ready tied high, alternating ADD/AND.
  - Required: one result every 2 cycles; each result matches a golden model.
  - Operand changes after accept never affect the result.
